// File: rtl/vga_frame_writer_pkg.sv
// ---------------------------------------------------------------------------
// vga_frame_writer_pkg
// Shared constants and types for the SRAM framebuffer writer.
//   REG_SIZE / ADDR_SIZE : sh_mem word and address widths, reused for the
//                          writer's DATA_W / SRC_AW defaults
//   FB_ADDR_W            : SRAM address width
//   FRAME_LEN            : words copied per frame
//   FB_BASE_ADDR         : SRAM address of frame word 0
//   WRITE_CYCLES         : cycles the SRAM write strobe is held per word
//   DISP_LOOKAHEAD       : offset added to the display pixel address
//   PREFETCH_DEPTH       : entries in the sh_mem prefetch FIFO
//   fw_state_t           : copy controller states
// ---------------------------------------------------------------------------
package vga_frame_writer_pkg;

   localparam int REG_SIZE       = 8;
   localparam int ADDR_SIZE      = 8;
   localparam int FB_ADDR_W      = 20;
   localparam int FRAME_LEN      = 256;
   localparam int FB_BASE_ADDR   = 0;
   localparam int WRITE_CYCLES   = 2;
   localparam int DISP_LOOKAHEAD = 1;
   localparam int PREFETCH_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COPY = 2'd1,
      DONE = 2'd2
   } fw_state_t;

endpackage

// File: rtl/vga_frame_writer_fifo.sv
// ---------------------------------------------------------------------------
// fb_fifo
// Small synchronous FIFO that decouples sh_mem prefetch from SRAM writes.
//   clk, reset : clock and synchronous active-high reset (empties the FIFO)
//   push, din  : write din at the tail
//   pop, dout  : dout always shows the head; pop advances past it
//   count      : number of stored entries
//   full/empty : status flags derived from count
// Push and pop in the same cycle both take effect and leave count unchanged.
// ---------------------------------------------------------------------------
module fb_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   localparam int PTR_W     = $clog2(FIFO_DEPTH),
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   assign dout  = mem[rd_ptr];
   assign full  = (count == CNT_W'(FIFO_DEPTH));
   assign empty = (count == '0);

   // Storage has no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; depth is a power of two so the
   // pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // A push into a full FIFO with no simultaneous pop would lose data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(push && full && !pop)) else $error("fb_fifo overflow");
      end
   end

endmodule

// File: rtl/vga_frame_writer.sv
// ---------------------------------------------------------------------------
// vga_frame_writer
// Writer end of the SRAM framebuffer. On copy_req it streams FRAME_WORDS
// words from the sh_mem VGA region into SRAM, writing only while
// copy_window is high. Whenever no write is in progress it drives the SRAM
// read path with the display lookahead address.
//   clk, reset        : clock and synchronous active-high reset
//   copy_req          : start a frame copy (level or pulse)
//   copy_window       : 1 = SRAM writes may start
//   src_rd, src_addr  : sh_mem read strobe and address
//   src_data          : sh_mem data, valid the cycle after src_rd
//   disp_addr         : current display pixel address
//   sram_wr, sram_rd  : SRAM strobes (sram_rd is always ~sram_wr)
//   sram_addr         : write address during a write, else display address
//   sram_wdata        : data of the word being written
//   busy              : copy in progress
//   frame_done        : one-cycle pulse when the last word has been written
// ---------------------------------------------------------------------------
module vga_frame_writer
   import vga_frame_writer_pkg::*;
#(
   parameter int DATA_W      = REG_SIZE,
   parameter int SRC_AW      = ADDR_SIZE,
   parameter int FB_AW       = FB_ADDR_W,
   parameter int FRAME_WORDS = FRAME_LEN,
   parameter int FB_BASE     = FB_BASE_ADDR,
   parameter int FIFO_DEPTH  = PREFETCH_DEPTH,
   parameter int WR_CYC      = WRITE_CYCLES,
   parameter int LOOKAHEAD   = DISP_LOOKAHEAD
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              copy_req,
   input  logic              copy_window,
   output logic              src_rd,
   output logic [SRC_AW-1:0] src_addr,
   input  logic [DATA_W-1:0] src_data,
   input  logic [FB_AW-1:0]  disp_addr,
   output logic              sram_wr,
   output logic              sram_rd,
   output logic [FB_AW-1:0]  sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   output logic              busy,
   output logic              frame_done
);

   localparam int IDX_W = $clog2(FRAME_WORDS + 1);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int WC_W  = $clog2(WR_CYC + 1);

   localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(FRAME_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
   localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WR_CYC - 1);
   localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

   fw_state_t         state;
   logic [IDX_W-1:0]  fetch_idx;
   logic [IDX_W-1:0]  write_idx;
   logic              inflight;
   logic [WC_W-1:0]   wr_cnt;
   logic [DATA_W-1:0] head;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              start_write;
   logic              wr_last;

   // A read is only issued when the FIFO is guaranteed a free slot for it,
   // counting the read still in flight from the previous cycle. Credit from
   // a pop shows up one cycle later, when fifo_count actually drops.
   assign src_rd = (state == COPY) && (fetch_idx < END_IDX) &&
                   (({1'b0, fifo_count} + (CNT_W + 1)'(inflight)) < DEPTH_C);
   assign src_addr = SRC_AW'(fetch_idx);

   // A new word write needs a buffered word, an idle write port and an open
   // window; a word already started always runs for its full WR_CYC cycles.
   assign start_write = (state == COPY) && !fifo_empty && !sram_wr && copy_window;
   assign wr_last     = sram_wr && (wr_cnt == WC_LAST);

   // The SRAM port is shared: write address while writing, otherwise the
   // display read address a little ahead of the beam.
   assign sram_rd   = ~sram_wr;
   assign sram_addr = sram_wr ? (FB_AW'(FB_BASE) + FB_AW'(write_idx))
                              : (disp_addr + FB_AW'(LOOKAHEAD));

   fb_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (inflight),
      .pop   (start_write),
      .din   (src_data),
      .dout  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Copy controller. Fetch and drain run side by side during COPY. The
   // FIFO needs no explicit flush on IDLE->COPY: it is empty after reset and
   // after a finished copy, since every fetched word has been written.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         fetch_idx  <= '0;
         write_idx  <= '0;
         inflight   <= 1'b0;
         wr_cnt     <= '0;
         sram_wr    <= 1'b0;
         sram_wdata <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         inflight   <= src_rd;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (copy_req) begin
                  state     <= COPY;
                  fetch_idx <= '0;
                  write_idx <= '0;
                  busy      <= 1'b1;
               end
            end
            COPY: begin
               if (src_rd) begin
                  fetch_idx <= fetch_idx + 1'b1;
               end
               if (start_write) begin
                  sram_wr    <= 1'b1;
                  wr_cnt     <= '0;
                  sram_wdata <= head;
               end else if (wr_last) begin
                  sram_wr   <= 1'b0;
                  write_idx <= write_idx + 1'b1;
                  if (write_idx == LAST_IDX) begin
                     state      <= DONE;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                  end
               end else if (sram_wr) begin
                  wr_cnt <= wr_cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_vga_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_writer
// Directed sequence with randomized sh_mem contents, display addresses and
// copy windows. A reference of the expected frame (word i goes to
// FB_BASE+i with sh_mem[i]) is kept in a plain array, and a cycle monitor
// compares every SRAM write and display read against it.
// ---------------------------------------------------------------------------
module tb_vga_frame_writer;

   localparam int FW      = 8;
   localparam int TB_BASE = 32'h00300;
   localparam int WRC     = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        copy_req;
   logic        copy_window;
   logic        src_rd;
   logic [7:0]  src_addr;
   logic [7:0]  src_data = 8'h00;
   logic [19:0] disp_addr;
   logic        sram_wr;
   logic        sram_rd;
   logic [19:0] sram_addr;
   logic [7:0]  sram_wdata;
   logic        busy;
   logic        frame_done;

   int total = 0;
   int passed = 0;
   int failed = 0;

   logic [7:0] src_mem [256];

   int  exp_word = 0;
   int  fetch_exp = 0;
   int  reads_seen = 0;
   int  writes_seen = 0;
   int  done_cnt = 0;
   bit  rand_win = 0;

   logic        m_prev_wr = 1'b0;
   logic        m_prev_win = 1'b0;
   int          m_wr_len = 0;
   logic [19:0] m_cur_addr;
   logic [7:0]  m_cur_data;
   logic [19:0] m_exp_disp;

   vga_frame_writer #(
      .FRAME_WORDS (FW),
      .FB_BASE     (TB_BASE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .copy_req    (copy_req),
      .copy_window (copy_window),
      .src_rd      (src_rd),
      .src_addr    (src_addr),
      .src_data    (src_data),
      .disp_addr   (disp_addr),
      .sram_wr     (sram_wr),
      .sram_rd     (sram_rd),
      .sram_addr   (sram_addr),
      .sram_wdata  (sram_wdata),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   // sh_mem model: data for a read appears the cycle after src_rd.
   always @(posedge clk) begin
      if (src_rd) src_data <= src_mem[src_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Cycle monitor: frame order, write hold/stability, window rule,
   // display address and strobe complement.
   always @(negedge clk) begin
      if (reset) begin
         m_prev_wr = 1'b0;
         m_wr_len  = 0;
      end else begin
         check("rd_is_not_wr", {31'd0, sram_rd}, {31'd0, ~sram_wr});
         if (!sram_wr) begin
            m_exp_disp = disp_addr + 20'd1;
            check("disp_rd_addr", {12'd0, sram_addr}, {12'd0, m_exp_disp});
         end
         if (src_rd) begin
            check("src_addr", {24'd0, src_addr}, fetch_exp);
            check("fetch_bound", {31'd0, fetch_exp < FW}, 1);
            fetch_exp++;
            reads_seen++;
         end
         if (sram_wr && !m_prev_wr) begin
            check("wr_window", {31'd0, m_prev_win}, 1);
            check("wr_bound", {31'd0, exp_word < FW}, 1);
            check("wr_addr", {12'd0, sram_addr}, TB_BASE + exp_word);
            check("wr_data", {24'd0, sram_wdata}, {24'd0, src_mem[exp_word[7:0]]});
            m_cur_addr = sram_addr;
            m_cur_data = sram_wdata;
            m_wr_len   = 1;
            exp_word++;
            writes_seen++;
         end else if (sram_wr) begin
            check("wr_hold_addr", {12'd0, sram_addr}, {12'd0, m_cur_addr});
            check("wr_hold_data", {24'd0, sram_wdata}, {24'd0, m_cur_data});
            m_wr_len++;
         end else if (m_prev_wr) begin
            check("wr_len", m_wr_len, WRC);
         end
         if (frame_done) begin
            check("done_busy_low", {31'd0, busy}, 0);
            done_cnt++;
         end
         m_prev_wr = sram_wr;
      end
      m_prev_win = copy_window;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      disp_addr = 20'($urandom);
      if (rand_win) copy_window = 1'($urandom_range(0, 1));
   endtask

   task automatic fill_mem(input bit ramp);
      for (int i = 0; i < FW; i++) begin
         src_mem[i] = ramp ? 8'(i + 16) : 8'($urandom);
      end
   endtask

   task automatic applyStimulus(input bit hold);
      exp_word    = 0;
      fetch_exp   = 0;
      reads_seen  = 0;
      writes_seen = 0;
      copy_req    = 1'b1;
      tick();
      if (!hold) copy_req = 1'b0;
      check("busy_at_entry", {31'd0, busy}, 1);
   endtask

   task automatic checkOutput(input int budget);
      int n = 0;
      while (frame_done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check("done_timeout", {31'd0, n < budget}, 1);
      check("done_busy", {31'd0, busy}, 0);
      check("done_all_words", exp_word, FW);
   endtask

   initial begin
      int snap;
      int n;
      for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
      reset       = 1'b1;
      copy_req    = 1'b0;
      copy_window = 1'b1;
      disp_addr   = 20'h00100;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("rst_sram_rd", {31'd0, sram_rd}, 1);
      check("rst_sram_addr", {12'd0, sram_addr}, 32'h00101);
      check("rst_sram_wr", {31'd0, sram_wr}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_src_rd", {31'd0, src_rd}, 0);
      check("rst_src_addr", {24'd0, src_addr}, 0);
      check("rst_wdata", {24'd0, sram_wdata}, 0);
      check("rst_done", {31'd0, frame_done}, 0);
      tick();

      // Ramp frame with the window always open.
      fill_mem(1'b1);
      applyStimulus(1'b0);
      checkOutput(200);
      tick();
      check("done_one_cycle", {31'd0, frame_done}, 0);
      tick();
      check("done_count_1", done_cnt, 1);
      check("writes_1", writes_seen, FW);

      // Closed window: prefetch fills the FIFO then stalls.
      fill_mem(1'b0);
      copy_window = 1'b0;
      applyStimulus(1'b0);
      repeat (19) tick();
      check("stall_reads", reads_seen, 4);
      check("stall_writes", writes_seen, 0);
      copy_window = 1'b1;
      checkOutput(200);
      tick();
      check("done_count_2", done_cnt, 2);

      // Window falls during the first cycle of a word write.
      fill_mem(1'b0);
      applyStimulus(1'b0);
      n = 0;
      while (sram_wr !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("first_wr_timeout", {31'd0, n < 50}, 1);
      copy_window = 1'b0;
      snap = writes_seen;
      repeat (10) tick();
      check("window_one_write", writes_seen - snap, 1);
      check("window_wr_low", {31'd0, sram_wr}, 0);
      copy_window = 1'b1;
      checkOutput(200);
      tick();

      // Reset in the middle of the fourth word.
      fill_mem(1'b0);
      applyStimulus(1'b0);
      n = 0;
      while (exp_word != 4 && n < 200) begin
         tick();
         n++;
      end
      check("mid_wait_timeout", {31'd0, n < 200}, 1);
      snap = done_cnt;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_src_rd", {31'd0, src_rd}, 0);
      check("mid_src_addr", {24'd0, src_addr}, 0);
      check("mid_sram_wr", {31'd0, sram_wr}, 0);
      check("mid_sram_rd", {31'd0, sram_rd}, 1);
      check("mid_wdata", {24'd0, sram_wdata}, 0);
      check("mid_busy", {31'd0, busy}, 0);
      check("mid_done", {31'd0, frame_done}, 0);
      reset = 1'b0;
      repeat (5) tick();
      check("mid_no_done", done_cnt, snap);
      fill_mem(1'b0);
      applyStimulus(1'b0);
      checkOutput(200);
      tick();
      check("restart_done", done_cnt, snap + 1);

      // copy_req held across a whole copy and its DONE cycle.
      fill_mem(1'b0);
      snap = done_cnt;
      applyStimulus(1'b1);
      checkOutput(200);
      exp_word  = 0;
      fetch_exp = 0;
      tick();
      check("held_idle_busy", {31'd0, busy}, 0);
      tick();
      check("held_restart_busy", {31'd0, busy}, 1);
      copy_req = 1'b0;
      checkOutput(200);
      tick();
      check("held_done_count", done_cnt, snap + 2);

      // Randomly flickering window.
      fill_mem(1'b0);
      rand_win = 1;
      applyStimulus(1'b0);
      checkOutput(2000);
      rand_win = 0;
      copy_window = 1'b1;
      tick();

      // Display address wrap.
      disp_addr = 20'hFFFFF;
      #1;
      check("disp_wrap", {12'd0, sram_addr}, 0);
      check("disp_wrap_rd", {31'd0, sram_rd}, 1);

      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/vga_frame_writer.md
Name: vga_frame_writer

Overview:
- Writer end of the SRAM framebuffer; vga_machine is the reader.
- On a copy request from the task scheduler, streams FRAME_WORDS words out of the sh_mem VGA region into SRAM, writing only inside the sync/blank copy window.
- Outside write slots it owns the SRAM read path for display (lookahead address) and pulses frame_done when the copy completes.
- Replaces the inline write/read/addr mux glue between sh_mem and sram_conn in GPU.

Parameters:
DATA_W, 8, word width (matches REG_SIZE)
SRC_AW, 8, sh_mem address width (matches ADDR_SIZE)
FB_AW, 20, SRAM address width
FRAME_WORDS, 256, words per frame copy
FB_BASE, 0, SRAM address of frame word 0
FIFO_DEPTH, 4, prefetch buffer entries (power of 2, >=2)
WR_CYC, 2, cycles sram_wr is held per word
LOOKAHEAD, 1, display read address offset

Ports:
clk  in  1  clock
reset  in  1  reset
copy_req  in  1  start frame copy (TS vga_en); level or pulse
copy_window  in  1  1 = SRAM writes permitted (~(h_sync & v_sync))
src_rd  out  1  sh_mem VGA-region read strobe
src_addr  out  SRC_AW  sh_mem read address
src_data  in  DATA_W  sh_mem read data, valid exactly 1 cycle after src_rd
disp_addr  in  FB_AW  vga_machine current pixel address
sram_wr  out  1  write strobe to sram_conn
sram_rd  out  1  read strobe to sram_conn, always equal to ~sram_wr
sram_addr  out  FB_AW  sram_conn address
sram_wdata  out  DATA_W  sram_conn write data
busy  out  1  copy in progress
frame_done  out  1  1-cycle pulse at end of copy (TS vga_end)

Behaviour:
- Interface: single clock, clk. reset is synchronous and active-high.
- Reset values: src_rd=0, src_addr=0, sram_wr=0, sram_rd=1, sram_wdata=0, busy=0, frame_done=0. FIFO empty; all counters 0.
- FSM states: IDLE, COPY, DONE.
  - IDLE: copy_req=1 -> COPY next cycle. Clear fetch index, write index and FIFO; busy=1 from the COPY entry cycle.
  - COPY: fetch and drain run concurrently. When the last word's write completes (write index reaches FRAME_WORDS and WR_CYC elapsed) -> DONE.
  - DONE: frame_done=1 and busy=0 for exactly one cycle -> IDLE. copy_req sampled in DONE is ignored; a held level restarts from IDLE on the next cycle.
- copy_req in COPY/DONE is ignored (no queuing).
- Fetch: src_rd=1 when fetch index < FRAME_WORDS and (fifo_count + inflight) < FIFO_DEPTH.
  - src_addr = fetch index; index increments per issued read.
  - Returned src_data is pushed one cycle later.
  - A pop in the same cycle does not free credit until the following cycle.
  - FIFO never overflows; a push to a full FIFO is an assertion error.
- Drain: a word write starts when FIFO non-empty, no write in progress, and copy_window=1.
  - Pop the head; hold sram_wr=1 for WR_CYC cycles with sram_addr = FB_BASE + write index and sram_wdata = head, all stable.
  - Write index increments at write end.
  - A write in progress always completes, even if copy_window falls mid-word. No new write starts while copy_window=0.
- Display read: when sram_wr=0, sram_rd=1 and sram_addr = disp_addr + LOOKAHEAD, modulo 2^FB_AW (wraps).
- Arithmetic: indices are clog2(FRAME_WORDS+1) bits. src_addr is truncated to SRC_AW. FB address adds modulo 2^FB_AW.
- Simultaneous push/pop with FIFO full or empty: push and pop both take effect; count unchanged.
- Reset mid-copy: immediate abort. FIFO flushed, no frame_done, sram_wr drops the next edge; a partial word is left in SRAM.
- FRAME_WORDS words only; fetch never exceeds index FRAME_WORDS-1.

Decomposition:
- Shared package/defines: FB_AW, FRAME_WORDS, FB_BASE, WR_CYC, LOOKAHEAD, the FSM state encoding (IDLE/COPY/DONE); reuse REG_SIZE/ADDR_SIZE for DATA_W/SRC_AW.
- One sub-module: fb_fifo. Synchronous FIFO with parameters DATA_W and FIFO_DEPTH; ports push, pop, din, dout, count, full, empty; same reset.

Test Plan:
- Reset then idle, disp_addr=0x00100 -> sram_rd=1, sram_addr=0x00101, sram_wr=0, busy=0.
- copy_window held 1, FRAME_WORDS=8, sh_mem[i]=i+0x10, copy_req pulse:
  - 8 writes, addresses FB_BASE+0..7, data 0x10..0x17, each sram_wr 2 cycles.
  - frame_done pulses once; busy low that cycle.
- copy_window=0 for the first 20 cycles:
  - src_rd issues exactly 4 reads, then stalls (FIFO full); no sram_wr.
  - After the window rises, all words written in order.
- copy_window falls in the first cycle of a word write -> that word completes its 2 cycles, the next write waits for the window; display reads resume in between.
- reset asserted mid-copy after 3 words -> all outputs at reset values next cycle; no frame_done. A new copy_req restarts from word 0.
- copy_req held high across the whole copy plus DONE:
  - no restart during COPY; one frame_done per copy.
  - second copy starts the cycle after DONE.
- disp_addr=0xFFFFF with LOOKAHEAD=1 -> sram_addr=0x00000.
